booth_mult_seq: RTL
===================

// Module: booth_mult_seq
// PURPOSE
//  Sequential signed multiplier (radix-2 Booth) for the ALU datapath. Drives the
//  existing adder_rca stage: it supplies x/y/carry_in and consumes sum each step.
//  Takes two N-bit two's-complement operands and returns a 2N-bit product after N
//  iterations. A start/busy/done handshake lets the ALU control issue one multiply.
// PARAMETERS
//  N   8   operand width in bits; adder and accumulator width is N+1
// PORTS
//  clk      in   1     single clock, rising edge
//  rst      in   1     synchronous, active-high reset
//  start    in   1     request; sampled only when state==IDLE
//  a        in   N     multiplicand M, signed; sampled with start
//  b        in   N     multiplier Q, signed; sampled with start
//  busy     out  1     high whenever state!=IDLE
//  done     out  1     one-cycle pulse; product is valid in that cycle
//  product  out  2N    signed result; registered, held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, product=0, A=0, Q=0, q_1=0, cnt=0.
//  Reset dominates. Asserted mid-operation, it aborts to IDLE, gives no done pulse
//   and clears product.
//  FSM: IDLE -(start)-> RUN -(cnt==N-1 step)-> DONE -> IDLE (unconditional).
//  Accept, edge k (IDLE & start):
//   - A<=0 (N+1 b); Q<=b; q_1<=0; M<=sign-ext(a) to N+1; cnt<=0.
//  RUN, edges k+1..k+N: one iteration per edge, selected by {Q[0],q_1}:
//   - 00/11: x=A, y=0,    cin=0 (hold)
//   - 01:    x=A, y=M,    cin=0 (A+M)
//   - 10:    x=A, y=~M,   cin=1 (A-M)
//   s = adder sum (N+1 b); carry_out unused.
//   Arithmetic right shift: A<={s[N],s[N:1]}; Q<={s[0],Q[N-1:1]}; q_1<=Q[0];
//   cnt<=cnt+1.
//  Edge k+N (last step):
//   - product<={A_next[N-1:0],Q_next}; state<=DONE.
//  DONE, cycle after edge k+N: done=1, busy=1. Next edge returns to IDLE.
//  Latency: done is high N cycles after the accept edge; earliest next accept is
//   edge k+N+2.
//  start while busy (RUN or DONE): ignored. Operand changes while busy: ignored.
//  Overflow: N+1-bit A cannot overflow, including M=-2^(N-1).
//   -2^(N-1) * -2^(N-1) = 2^(2N-2) fits in 2N bits.
//  The adder is driven combinationally in every state. In IDLE/DONE use y=0, cin=0.
// STRUCTURE
//  Package booth_pkg:
//   - state encodings IDLE/RUN/DONE (2-bit localparams)
//   - Booth select codes OP_NOP/OP_ADD/OP_SUB
//   - CNT_W = $clog2(N)
//  Sub-module: exactly one adder_rca #(.w(N+1)) instance. No other adder in this
//   block. FSM, counter and shift registers live here.
// TESTING
//  1 a=3,b=2, start 1 cycle -> done N=8 cycles after accept, product=16'h0006
//  2 a=-1,b=1 -> product=16'hFFFF; a=0,b=-128 -> 16'h0000
//  3 a=-128,b=-128 -> product=16'h4000; a=127,b=-128 -> 16'hC080
//  4 start held high through busy -> exactly one done pulse per accept; product
//    unchanged by a/b toggling mid-run
//  5 rst pulsed after 4th iteration -> next cycle busy=0, product=0, no done; then
//    a=5,b=-3 -> 16'hFFF1
//  6 start re-asserted in cycle after done -> accepted that edge; a=-7,b=9 ->
//    16'hFFC1, done N cycles later
//  Self-check every case against $signed(a)*$signed(b). Add 1000 random pairs.

Source files
------------

// File: rtl/booth_pkg.sv
// Purpose: shared definitions for the radix-2 Booth sequential multiplier.
//   - FSM state encodings and the enum built on them
//   - Booth step select codes and the decoder from {Q[0], q_1}
//   - counter width helper (CNT_W for the default operand width)
package booth_pkg;

    localparam int N_DEFAULT = 8;

    // Step counter width for an n-step run; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(N_DEFAULT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    // Radix-2 Booth recoding: 01 -> +M, 10 -> -M, 00/11 -> no change.
    function automatic logic [1:0] booth_op(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/adder_rca.sv
// Purpose: w-bit ripple-carry adder used as the multiplier's datapath adder.
// Ports:
//   x, y       in  w  addends
//   carry_in   in  1  carry into bit 0
//   sum        out w  x + y + carry_in (modulo 2^w)
//   carry_out  out 1  carry out of bit w-1
module adder_rca #(
    parameter int w = 9
) (
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    input  logic         carry_in,
    output logic [w-1:0] sum,
    output logic         carry_out
);

    always_comb begin
        logic carry;
        carry = carry_in;
        sum   = '0;
        for (int i = 0; i < w; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        carry_out = carry;
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Purpose: sequential signed N x N multiplier using radix-2 Booth recoding.
//   One Booth step per clock through a single (N+1)-bit ripple adder; the
//   2N-bit product is registered and held until the next completed multiply.
// Ports:
//   clk      in  1   rising-edge clock
//   rst      in  1   synchronous active-high reset, dominates everything
//   start    in  1   multiply request, only looked at in IDLE
//   a        in  N   signed multiplicand, captured with start
//   b        in  N   signed multiplier, captured with start
//   busy     out 1   high in RUN and DONE
//   done     out 1   one-cycle pulse while product first holds the new result
//   product  out 2N  signed product
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = cnt_w(N);

    state_t          state_q;
    logic [N:0]      acc_q;      // A: upper half of the shifting pair, one guard bit
    logic [N:0]      m_q;        // sign-extended multiplicand
    logic [N-1:0]    q_q;        // Q: multiplier, shifts out as product bits shift in
    logic            q1_q;       // bit shifted out of Q last step
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  product_q;
    logic            busy_q;
    logic            done_q;

    logic [1:0]      op;
    logic [N:0]      add_y;
    logic            add_cin;
    logic [N:0]      add_sum;
    logic            add_cout_unused;
    logic [N:0]      acc_next;
    logic [N-1:0]    q_next;
    logic            last_step;

    // Adder operands: only RUN applies the Booth selection; otherwise A + 0.
    always_comb begin
        op      = booth_op(q_q[0], q1_q);
        add_y   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            case (op)
                OP_ADD:  add_y = m_q;
                OP_SUB: begin
                    add_y   = ~m_q;
                    add_cin = 1'b1;
                end
                default: add_y = '0;
            endcase
        end
    end

    adder_rca #(.w(N + 1)) u_adder (
        .x         (acc_q),
        .y         (add_y),
        .carry_in  (add_cin),
        .sum       (add_sum),
        .carry_out (add_cout_unused)
    );

    // Arithmetic right shift of the {A, Q} pair.
    assign acc_next  = {add_sum[N], add_sum[N:1]};
    assign q_next    = {add_sum[0], q_q[N-1:1]};
    assign last_step = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        q_q     <= b;
                        q1_q    <= 1'b0;
                        m_q     <= {a[N-1], a};
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    q_q   <= q_next;
                    q1_q  <= q_q[0];
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        product_q <= {acc_next[N-1:0], q_next};
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
